// File: rtl/simple_risc_pkg.sv
// Shared encodings for the Simple RISC Machine core: opcodes, shift/ALU codes, FSM states,
// memory command codes and the B-operand shifter helper.
package simple_risc_pkg;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_MVN  = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ROR  = 2'b11;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  typedef enum logic [2:0] {
    StWait     = 3'd0,
    StDecode   = 3'd1,
    StGetA     = 3'd2,
    StGetB     = 3'd3,
    StAlu      = 3'd4,
    StWriteRd  = 3'd5,
    StWriteImm = 3'd6
  } state_e;

  function automatic logic [15:0] shift_b(input logic [1:0] sh, input logic [15:0] b);
    case (sh)
      SH_LSL:  return {b[14:0], 1'b0};
      SH_LSR:  return {1'b0, b[15:1]};
      SH_ROR:  return {b[0], b[15:1]};
      default: return b;
    endcase
  endfunction

endpackage

// File: rtl/simple_risc_datapath.sv
// Datapath: 8x16 register file (not reset), A/B/C operand registers, B shifter, ALU and
// the {V,N,Z} status register.
module simple_risc_datapath
  import simple_risc_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [2:0]  i_rn,
  input  logic [2:0]  i_rm,
  input  logic [2:0]  i_wnum,
  input  logic        i_write,
  input  logic        i_wsel_imm,
  input  logic [15:0] i_imm,
  input  logic        i_load_a,
  input  logic        i_load_b,
  input  logic        i_load_c,
  input  logic        i_load_s,
  input  logic        i_zero_a,
  input  logic [1:0]  i_shift,
  input  logic [1:0]  i_aluop,
  output logic [15:0] o_c,
  output logic [2:0]  o_stat
);

  logic [15:0] r_regs [8];
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [15:0] r_c;
  logic [2:0]  r_stat;

  logic [15:0] w_wdata;
  logic [15:0] w_a;
  logic [15:0] w_b;
  logic [15:0] w_res;
  logic        w_v;

  assign w_wdata = i_wsel_imm ? i_imm : r_c;

  always_ff @(posedge i_clk) begin
    if (i_write) r_regs[i_wnum] <= w_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= '0;
      r_stat <= '0;
    end else begin
      if (i_load_a) r_a <= r_regs[i_rn];
      if (i_load_b) r_b <= r_regs[i_rm];
      if (i_load_c) r_c <= w_res;
      if (i_load_s) r_stat <= {w_v, w_res[15], (w_res == 16'd0)};
    end
  end

  assign w_a = i_zero_a ? 16'd0 : r_a;
  assign w_b = shift_b(i_shift, r_b);

  always_comb begin
    w_res = 16'd0;
    w_v   = 1'b0;
    case (i_aluop)
      ALU_ADD: begin
        w_res = w_a + w_b;
        w_v   = (w_a[15] == w_b[15]) && (w_res[15] != w_a[15]);
      end
      ALU_SUB: begin
        w_res = w_a - w_b;
        w_v   = (w_a[15] != w_b[15]) && (w_res[15] != w_a[15]);
      end
      ALU_AND:  w_res = w_a & w_b;
      default:  w_res = ~w_b;
    endcase
  end

  assign o_c    = r_c;
  assign o_stat = r_stat;

endmodule

// File: rtl/simple_risc_cpu.sv
// Simple RISC Machine core top: instruction register, decoder and Moore controller.
// Build option CPU_FLAGS_ALL_EN: every ALU-state instruction updates status, not only CMP.
module simple_risc_cpu
  import simple_risc_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_mdata,
  input  logic        i_s,
  input  logic        i_load,
  input  logic [15:0] i_in,
  output logic [15:0] o_out,
  output logic        o_n,
  output logic        o_v,
  output logic        o_z,
  output logic        o_w,
  output logic [1:0]  o_mem_cmd,
  output logic [8:0]  o_mem_addr
);

  state_e      r_state;
  state_e      w_state_next;
  logic [15:0] r_ir;

  logic [2:0]  w_opcode;
  logic [1:0]  w_op;
  logic [2:0]  w_rn;
  logic [2:0]  w_rd;
  logic [1:0]  w_sh;
  logic [2:0]  w_rm;
  logic [15:0] w_imm;
  logic        w_mov_imm;
  logic        w_mov_reg;
  logic        w_alu;
  logic        w_unary;
  logic        w_cmp;

  logic        w_load_a;
  logic        w_load_b;
  logic        w_load_c;
  logic        w_load_s;
  logic        w_write;
  logic        w_wsel_imm;
  logic [2:0]  w_wnum;
  logic        w_zero_a;
  logic [1:0]  w_aluop;
  logic [2:0]  w_stat;
  logic        w_unused_mdata;

  assign w_unused_mdata = ^i_mdata;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_ir <= '0;
    else if (i_load) r_ir <= i_in;
  end

  assign w_opcode  = r_ir[15:13];
  assign w_op      = r_ir[12:11];
  assign w_rn      = r_ir[10:8];
  assign w_rd      = r_ir[7:5];
  assign w_sh      = r_ir[4:3];
  assign w_rm      = r_ir[2:0];
  assign w_imm     = {{8{r_ir[7]}}, r_ir[7:0]};
  assign w_mov_imm = (w_opcode == OPC_MOV) && (w_op == OP_MOVI);
  assign w_mov_reg = (w_opcode == OPC_MOV) && (w_op == OP_MOVR);
  assign w_alu     = (w_opcode == OPC_ALU);
  assign w_unary   = w_mov_reg || (w_alu && (w_op == OP_MVN));
  assign w_cmp     = w_alu && (w_op == OP_CMP);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StWait;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StWait:     if (i_s) w_state_next = StDecode;
      StDecode: begin
        if (w_mov_imm)    w_state_next = StWriteImm;
        else if (w_unary) w_state_next = StGetB;
        else if (w_alu)   w_state_next = StGetA;
        else              w_state_next = StWait;
      end
      StGetA:     w_state_next = StGetB;
      StGetB:     w_state_next = StAlu;
      StAlu:      w_state_next = StWriteRd;
      StWriteRd:  w_state_next = StWait;
      StWriteImm: w_state_next = StWait;
      default:    w_state_next = StWait;
    endcase
  end

  always_comb begin
    w_load_a   = (r_state == StGetA);
    w_load_b   = (r_state == StGetB);
    w_load_c   = (r_state == StAlu);
`ifdef CPU_FLAGS_ALL_EN
    w_load_s   = (r_state == StAlu);
`else
    w_load_s   = (r_state == StAlu) && w_cmp;
`endif
    w_write    = (r_state == StWriteRd) || (r_state == StWriteImm);
    w_wsel_imm = (r_state == StWriteImm);
    w_wnum     = (r_state == StWriteImm) ? w_rn : w_rd;
    // ALU op codes line up with the op field; MOV-reg is 0 + sh(Rm)
    w_zero_a   = w_mov_reg;
    w_aluop    = w_mov_reg ? ALU_ADD : w_op;
    o_w        = (r_state == StWait);
  end

  simple_risc_datapath u_datapath (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_rn       (w_rn),
    .i_rm       (w_rm),
    .i_wnum     (w_wnum),
    .i_write    (w_write),
    .i_wsel_imm (w_wsel_imm),
    .i_imm      (w_imm),
    .i_load_a   (w_load_a),
    .i_load_b   (w_load_b),
    .i_load_c   (w_load_c),
    .i_load_s   (w_load_s),
    .i_zero_a   (w_zero_a),
    .i_shift    (w_sh),
    .i_aluop    (w_aluop),
    .o_c        (o_out),
    .o_stat     (w_stat)
  );

  assign o_v        = w_stat[2];
  assign o_n        = w_stat[1];
  assign o_z        = w_stat[0];
  assign o_mem_cmd  = MNONE;
  assign o_mem_addr = 9'd0;

endmodule

// File: tb/tb_simple_risc_cpu.sv
// Directed-vector bench for simple_risc_cpu: results, flags, w latency and mid-instruction reset.
module tb_simple_risc_cpu;

  logic        clk;
  logic        rst_n;
  logic [15:0] mdata;
  logic        s;
  logic        load;
  logic [15:0] in_w;
  logic [15:0] out_w;
  logic        n_f;
  logic        v_f;
  logic        z_f;
  logic        w_f;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;

  int n_vec = 0;
  int n_err = 0;

  simple_risc_cpu dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_mdata    (mdata),
    .i_s        (s),
    .i_load     (load),
    .i_in       (in_w),
    .o_out      (out_w),
    .o_n        (n_f),
    .o_v        (v_f),
    .o_z        (z_f),
    .o_w        (w_f),
    .o_mem_cmd  (mem_cmd),
    .o_mem_addr (mem_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
    end
  endtask

  // Load instr, pulse s (held for `hold` edges), check w drops and rises after `lat` edges.
  task automatic exec(input logic [15:0] instr, input int lat, input int hold);
    int n;
    in_w = instr;
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    s    = 1'b1;
    @(posedge clk); #1;
    n = 1;
    if (n >= hold) s = 1'b0;
    check($sformatf("w_low_%04h", instr), {15'd0, w_f}, 16'd0);
    while (!w_f && n < 16) begin
      @(posedge clk); #1;
      n++;
      if (n >= hold) s = 1'b0;
    end
    s = 1'b0;
    check($sformatf("latency_%04h", instr), 16'(n), 16'(lat));
  endtask

  // MOV Rx,Rx puts Rx on out without changing it.
  task automatic read_reg(input int r, input logic [15:0] exp);
    logic [15:0] instr;
    instr = 16'hC000 | 16'(r << 5) | 16'(r);
    exec(instr, 5, 1);
    check($sformatf("R%0d", r), out_w, exp);
  endtask

  function automatic logic [15:0] stat16();
    return {13'd0, v_f, n_f, z_f};
  endfunction

  initial begin
    rst_n = 1'b0;
    mdata = 16'hA5A5;
    s     = 1'b0;
    load  = 1'b0;
    in_w  = 16'h0000;
    #12;
    check("rst_w", {15'd0, w_f}, 16'd1);
    check("rst_out", out_w, 16'd0);
    check("rst_stat", stat16(), 16'd0);
    check("rst_mem_cmd", {14'd0, mem_cmd}, 16'd0);
    check("rst_mem_addr", {7'd0, mem_addr}, 16'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    exec(16'hD007, 3, 1); check("movi_keeps_c", out_w, 16'h0000);
    exec(16'hC028, 5, 1); check("mov_lsl", out_w, 16'h000E);
    exec(16'hA148, 6, 1); check("add_lsl", out_w, 16'h001C);
    exec(16'hD307, 3, 3);
    exec(16'hAAA8, 6, 1); check("cmp1_out", out_w, 16'h000E); check("cmp1_st", stat16(), 16'h0);
    exec(16'hA8C1, 6, 1); check("cmp2_out", out_w, 16'hFFF9); check("cmp2_st", stat16(), 16'h2);
    exec(16'hAB80, 6, 1); check("cmp3_out", out_w, 16'h0000); check("cmp3_st", stat16(), 16'h1);
    exec(16'hB8E6, 5, 1); check("mvn", out_w, 16'h0006);
`ifdef CPU_FLAGS_ALL_EN
    check("mvn_st", stat16(), 16'h0);
`else
    check("mvn_st", stat16(), 16'h1);
`endif
    exec(16'hB6ED, 6, 1); check("and", out_w, 16'h0018);
    exec(16'hD001, 3, 1); check("movi_keeps_c2", out_w, 16'h0018);
    exec(16'hC018, 5, 1); check("ror", out_w, 16'h8000);
    exec(16'hC030, 5, 1); check("lsr", out_w, 16'h4000);
    exec(16'hB841, 5, 1); check("mvn2", out_w, 16'hBFFF);
    exec(16'hA962, 6, 1); check("cmp_ovf", out_w, 16'h8001); check("cmp_ovf_st", stat16(), 16'h6);
    exec(16'hB881, 5, 1); check("mvn_r4", out_w, 16'hBFFF);
    exec(16'hB4A1, 6, 1); check("and_zero", out_w, 16'h0000);
`ifdef CPU_FLAGS_ALL_EN
    check("and_zero_st", stat16(), 16'h1);
`else
    check("and_zero_st", stat16(), 16'h6);
`endif
    exec(16'hA4C1, 6, 1); check("add_ffff", out_w, 16'hFFFF);
`ifdef CPU_FLAGS_ALL_EN
    check("add_ffff_st", stat16(), 16'h2);
`else
    check("add_ffff_st", stat16(), 16'h6);
`endif
    exec(16'h0000, 2, 1); check("illegal_out", out_w, 16'hFFFF);

    read_reg(0, 16'h8000);
    read_reg(3, 16'h8001);
    read_reg(5, 16'h0000);
    read_reg(7, 16'h0018);

    // ADD R7 = R1 + R1, aborted by reset while in WRITE_RD
    in_w = 16'hA1E1;
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    s    = 1'b1;
    @(posedge clk); #1;
    s = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre_abort_c", out_w, 16'h8000);
    rst_n = 1'b0;
    #2;
    check("abort_w", {15'd0, w_f}, 16'd1);
    check("abort_out", out_w, 16'd0);
    check("abort_stat", stat16(), 16'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    read_reg(7, 16'h0018);
    read_reg(1, 16'h4000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
